// File: rtl/snake_body_ctrl.sv
// Snake body controller: keeps the head cell, pushes new heads into an external
// segment queue and pops/erases the tail cell on every non-growing move.
module snake_body_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int COORD_W  = 6,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 10,
    parameter int START_Y  = 15
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   tick,
    input  logic [1:0]             dir,
    input  logic                   grow,
    output logic                   q_write_en,
    output logic [2*COORD_W-1:0]   q_write_data,
    output logic                   q_read_en,
    input  logic [2*COORD_W-1:0]   q_read_data,
    input  logic                   q_full,
    input  logic                   q_empty,
    output logic [COORD_W-1:0]     head_x,
    output logic [COORD_W-1:0]     head_y,
    output logic [COORD_W-1:0]     tail_x,
    output logic [COORD_W-1:0]     tail_y,
    output logic                   tail_valid,
    output logic                   busy,
    output logic                   overflow,
    output logic [ADDR_W:0]        length,
    output logic [2:0]             dbg_state
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_PUSH = 3'd2;
    localparam logic [2:0] S_POP  = 3'd3;
    localparam logic [2:0] S_CAPT = 3'd4;

    localparam logic [ADDR_W:0]    MAX_LEN  = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]    INIT_END = (ADDR_W+1)'(INIT_LEN-1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(GRID_W-1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(GRID_H-1);

    // Handshake: the queue accepts q_write_data on any posedge with q_write_en=1,
    // and returns q_read_data on the posedge after a cycle with q_read_en=1.
    logic [2:0]         state;
    logic [1:0]         heading;
    logic               grow_q;
    logic               pop_first;
    logic               popped;
    logic [ADDR_W:0]    init_cnt;
    logic [COORD_W-1:0] tx, ty;
    logic [COORD_W-1:0] nx, ny;
    logic               can_grow;
    logic               dir_ok;

    always_comb begin
        nx = head_x;
        ny = head_y;
        case (heading)
            2'd0:    ny = (head_y == '0) ? Y_LAST : head_y - 1'b1;
            2'd1:    nx = (head_x == X_LAST) ? '0 : head_x + 1'b1;
            2'd2:    ny = (head_y == Y_LAST) ? '0 : head_y + 1'b1;
            default: nx = (head_x == '0) ? X_LAST : head_x - 1'b1;
        endcase
    end

    assign can_grow = grow && (length < MAX_LEN) && !q_full;
    assign dir_ok   = (dir != (heading ^ 2'b10));

    // Strobes are gated by Reset so nothing reaches the queue while INIT is held.
    assign q_write_en   = Reset && ((state == S_INIT) || (state == S_PUSH));
    assign q_write_data = {nx, ny};
    assign q_read_en    = Reset && (state == S_POP) && !q_empty;
    assign tail_valid   = Reset && (state == S_CAPT) && popped;
    assign tail_x       = tail_valid ? q_read_data[2*COORD_W-1:COORD_W] : tx;
    assign tail_y       = tail_valid ? q_read_data[COORD_W-1:0] : ty;
    assign busy         = (state != S_IDLE);
    assign dbg_state    = state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_INIT;
            heading   <= 2'd1;
            head_x    <= COORD_W'(START_X - INIT_LEN);
            head_y    <= COORD_W'(START_Y);
            tx        <= '0;
            ty        <= '0;
            length    <= '0;
            init_cnt  <= '0;
            grow_q    <= 1'b0;
            pop_first <= 1'b0;
            popped    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (q_write_en) begin
                length <= length + 1'b1;
            end else if (q_read_en) begin
                length <= length - 1'b1;
            end
            case (state)
                S_INIT: begin
                    head_x   <= nx;
                    head_y   <= ny;
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_END) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (tick) begin
                        if (dir_ok) begin
                            heading <= dir;
                        end
                        grow_q    <= can_grow;
                        overflow  <= grow && !can_grow;
                        // A full queue must release the tail before taking a new head.
                        pop_first <= !can_grow && (length == MAX_LEN);
                        state     <= (!can_grow && (length == MAX_LEN)) ? S_POP : S_PUSH;
                    end
                end
                S_PUSH: begin
                    head_x <= nx;
                    head_y <= ny;
                    state  <= (grow_q || pop_first) ? S_IDLE : S_POP;
                end
                S_POP: begin
                    popped <= !q_empty;
                    state  <= S_CAPT;
                end
                S_CAPT: begin
                    if (popped) begin
                        tx <= q_read_data[2*COORD_W-1:COORD_W];
                        ty <= q_read_data[COORD_W-1:0];
                    end
                    state <= pop_first ? S_PUSH : S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: behavioural segment queue, directed moves, and a
// scoreboard of expected queue writes, tail releases and overflow pulses.
module tb_snake_body_ctrl;

    logic        Clk;
    logic        Reset;
    logic        tick;
    logic [1:0]  dir;
    logic        grow;
    logic        q_write_en;
    logic [11:0] q_write_data;
    logic        q_read_en;
    logic [11:0] q_read_data;
    logic        q_full;
    logic        q_empty;
    logic [5:0]  head_x, head_y, tail_x, tail_y;
    logic        tail_valid;
    logic        busy;
    logic        overflow;
    logic [4:0]  length;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [11:0] exp_wr_q[$];
    logic [11:0] exp_tail_q[$];
    logic [0:0]  exp_ovf_q[$];
    logic [11:0] body_q[$];

    logic [5:0]  m_hx, m_hy;
    logic [1:0]  m_head;
    int          m_len;

    logic [11:0] qmem[16];
    logic [4:0]  qcnt;
    logic [3:0]  qwp, qrp;

    localparam logic [15:0] TR_NORM = 16'h9530;
    localparam logic [15:0] TR_GROW = 16'h9000;
    localparam logic [15:0] TR_FULL = 16'h5390;
    localparam logic [15:0] TR_INIT = 16'h9990;

    snake_body_ctrl dut (
        .Clk(Clk), .Reset(Reset), .tick(tick), .dir(dir), .grow(grow),
        .q_write_en(q_write_en), .q_write_data(q_write_data),
        .q_read_en(q_read_en), .q_read_data(q_read_data),
        .q_full(q_full), .q_empty(q_empty),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .tail_valid(tail_valid), .busy(busy), .overflow(overflow),
        .length(length), .dbg_state(dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Segment queue: write at rear, registered read from front, cleared by Reset.
    assign q_full  = (qcnt == 5'd16);
    assign q_empty = (qcnt == 5'd0);
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            qcnt        <= '0;
            qwp         <= '0;
            qrp         <= '0;
            q_read_data <= '0;
        end else begin
            if (q_write_en && !q_full) begin
                qmem[qwp] <= q_write_data;
                qwp       <= qwp + 1'b1;
            end
            if (q_read_en && !q_empty) begin
                q_read_data <= qmem[qrp];
                qrp         <= qrp + 1'b1;
            end
            qcnt <= qcnt + 5'((q_write_en && !q_full) ? 1 : 0) - 5'((q_read_en && !q_empty) ? 1 : 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output event pops the matching expectation.
    always @(negedge Clk) begin
        if (Reset) begin
            if (q_write_en) begin
                if (exp_wr_q.size() == 0) check("sb_write_unexpected", {20'd0, q_write_data}, 32'hffffffff);
                else check("sb_write", {20'd0, q_write_data}, {20'd0, exp_wr_q.pop_front()});
            end
            if (tail_valid) begin
                if (exp_tail_q.size() == 0) check("sb_tail_unexpected", {20'd0, tail_x, tail_y}, 32'hffffffff);
                else check("sb_tail", {20'd0, tail_x, tail_y}, {20'd0, exp_tail_q.pop_front()});
            end
            if (overflow) begin
                if (exp_ovf_q.size() == 0) check("sb_overflow_unexpected", 32'd1, 32'd0);
                else check("sb_overflow", 32'd1, {31'd0, exp_ovf_q.pop_front()});
            end
        end
    end

    function automatic logic [11:0] step(input logic [5:0] x, input logic [5:0] y, input logic [1:0] h);
        logic [5:0] nx, ny;
        nx = x;
        ny = y;
        case (h)
            2'd0:    ny = (y == 6'd0) ? 6'd29 : y - 6'd1;
            2'd1:    nx = (x == 6'd39) ? 6'd0 : x + 6'd1;
            2'd2:    ny = (y == 6'd29) ? 6'd0 : y + 6'd1;
            default: nx = (x == 6'd0) ? 6'd39 : x - 6'd1;
        endcase
        return {nx, ny};
    endfunction

    task automatic model_move(input logic [1:0] d, input logic g);
        logic [11:0] nh;
        logic        cg;
        if (d != (m_head ^ 2'b10)) m_head = d;
        nh = step(m_hx, m_hy, m_head);
        cg = g && (m_len < 16);
        if (g && !cg) exp_ovf_q.push_back(1'b1);
        exp_wr_q.push_back(nh);
        body_q.push_back(nh);
        if (cg) m_len++;
        else exp_tail_q.push_back(body_q.pop_front());
        m_hx = nh[11:6];
        m_hy = nh[5:0];
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_move(input logic [1:0] d, input logic g, input logic extra, output logic [15:0] tr);
        wait_idle();
        @(negedge Clk);
        tick = 1'b1;
        dir  = d;
        grow = g;
        model_move(d, g);
        @(posedge Clk);
        #1;
        tick = 1'b0;
        grow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            tr[15-4*i -: 4] = {q_write_en, q_read_en, tail_valid, busy};
            if (extra && i == 0) begin
                tick = 1'b1;
                dir  = 2'd2;
            end else begin
                tick = 1'b0;
            end
        end
    endtask

    task automatic reset_and_init();
        logic [15:0] tr;
        Reset = 1'b0;
        tick  = 1'b0;
        exp_wr_q.delete();
        exp_tail_q.delete();
        exp_ovf_q.delete();
        body_q.delete();
        body_q.push_back({6'd8, 6'd15});
        body_q.push_back({6'd9, 6'd15});
        body_q.push_back({6'd10, 6'd15});
        foreach (body_q[i]) exp_wr_q.push_back(body_q[i]);
        m_hx = 6'd10; m_hy = 6'd15; m_head = 2'd1; m_len = 3;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            tr[15-4*i -: 4] = {q_write_en, q_read_en, tail_valid, busy};
        end
        check("init_trace", {16'd0, tr}, {16'd0, TR_INIT});
        check("init_length", {27'd0, length}, 32'd3);
        check("init_head", {20'd0, head_x, head_y}, {20'd0, 6'd10, 6'd15});
        check("init_state_idle", {29'd0, dbg_state}, 32'd1);
    endtask

    initial begin
        logic [15:0] tr;
        Reset = 1'b0;
        tick  = 1'b0;
        dir   = 2'd0;
        grow  = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_strobes", {28'd0, q_write_en, q_read_en, tail_valid, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_length", {27'd0, length}, 32'd0);
        check("rst_head", {20'd0, head_x, head_y}, {20'd0, 6'd7, 6'd15});
        check("rst_tail", {20'd0, tail_x, tail_y}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);

        reset_and_init();

        // Plain move right: write, read, tail release, back to idle.
        do_move(2'd1, 1'b0, 1'b0, tr);
        check("move_trace", {16'd0, tr}, {16'd0, TR_NORM});
        check("move_tail", {20'd0, tail_x, tail_y}, {20'd0, 6'd8, 6'd15});
        check("move_length", {27'd0, length}, 32'd3);
        check("move_head", {20'd0, head_x, head_y}, {20'd0, 6'd11, 6'd15});

        for (int i = 0; i < 28; i++) do_move(2'd1, 1'b0, 1'b0, tr);
        check("head_x39", {20'd0, head_x, head_y}, {20'd0, 6'd39, 6'd15});
        do_move(2'd1, 1'b0, 1'b0, tr);
        check("wrap_right", {20'd0, head_x, head_y}, {20'd0, 6'd0, 6'd15});

        for (int i = 0; i < 10; i++) do_move(2'd1, 1'b0, 1'b0, tr);
        for (int i = 0; i < 15; i++) do_move(2'd0, 1'b0, 1'b0, tr);
        check("head_y0", {20'd0, head_x, head_y}, {20'd0, 6'd10, 6'd0});
        do_move(2'd0, 1'b0, 1'b0, tr);
        check("wrap_up", {20'd0, head_x, head_y}, {20'd0, 6'd10, 6'd29});

        // Reverse requests are ignored; extra tick while busy is dropped.
        do_move(2'd2, 1'b0, 1'b0, tr);
        check("reverse_up", {20'd0, head_x, head_y}, {20'd0, 6'd10, 6'd28});
        do_move(2'd1, 1'b0, 1'b1, tr);
        check("busy_tick_trace", {16'd0, tr}, {16'd0, TR_NORM});
        check("busy_tick_head", {20'd0, head_x, head_y}, {20'd0, 6'd11, 6'd28});
        do_move(2'd3, 1'b0, 1'b0, tr);
        check("reverse_right", {20'd0, head_x, head_y}, {20'd0, 6'd12, 6'd28});

        do_move(2'd1, 1'b1, 1'b0, tr);
        check("grow_trace", {16'd0, tr}, {16'd0, TR_GROW});
        check("grow_length", {27'd0, length}, 32'd4);
        for (int i = 0; i < 12; i++) do_move(2'd1, 1'b1, 1'b0, tr);
        check("grow_full", {27'd0, length}, 32'd16);
        do_move(2'd1, 1'b1, 1'b0, tr);
        check("overflow_trace", {16'd0, tr}, {16'd0, TR_FULL});
        check("overflow_length", {27'd0, length}, 32'd16);
        do_move(2'd2, 1'b0, 1'b0, tr);
        check("full_move_trace", {16'd0, tr}, {16'd0, TR_FULL});
        check("full_move_length", {27'd0, length}, 32'd16);
        check("full_move_head", {20'd0, head_x, head_y}, {20'd0, 6'd26, 6'd29});

        // Reset during the read cycle of a move.
        wait_idle();
        @(negedge Clk);
        tick = 1'b1;
        dir  = 2'd1;
        model_move(2'd1, 1'b0);
        @(posedge Clk);
        #1;
        tick = 1'b0;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("midrst_strobes", {28'd0, q_write_en, q_read_en, tail_valid, overflow}, 32'd0);
        check("midrst_length", {27'd0, length}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        reset_and_init();

        do_move(2'd1, 1'b0, 1'b0, tr);
        check("post_rst_trace", {16'd0, tr}, {16'd0, TR_NORM});
        check("post_rst_tail", {20'd0, tail_x, tail_y}, {20'd0, 6'd8, 6'd15});

        repeat (3) @(negedge Clk);
        check("sb_drain", exp_wr_q.size() + exp_tail_q.size() + exp_ovf_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
